inv_gamma_stream: RTL
=====================

# inv_gamma_stream

Streaming inverse-gamma (degamma) stage for the HDMI pixel path. It linearises gamma-encoded RGB888 video using a host-loadable 256-entry lookup table that holds the inverse of the forward gamma curve. The table is double-buffered, and a newly loaded table takes effect only at a frame boundary, so a frame never mixes two tables. The block sits between the video timing/source stage and downstream pixel processing, with fixed latency and sync signals delayed to match.

## Interface
- DATA_W, 8: colour channel width; only 8 is supported.
- LUT_DEPTH, 256: table entries, equal to 2**DATA_W.
- clk  in  1  pixel clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- i_vs, i_hs, i_de  in  1 each  input vsync, hsync and data enable.
- i_r, i_g, i_b  in  8 each  gamma-encoded input pixel.
- o_vs, o_hs, o_de  out  1 each  syncs delayed by the pipeline latency.
- o_r, o_g, o_b  out  8 each  linearised output pixel.
- bypass  in  1  1 = pass the pixel through unchanged, with the same latency.
- cfg_wr_en  in  1  writes cfg_data to shadow-table entry cfg_addr. Accepted only while cfg_ready=1.
- cfg_addr  in  8  shadow-table write address.
- cfg_data  in  8  shadow-table write data.
- cfg_commit  in  1  one-cycle pulse that arms the table swap at the next frame start.
- cfg_ready  out  1  1 = shadow table is writable and a commit is accepted.
- init_done  out  1  1 = startup sequence complete.

## Operation
- Table storage is two banks, A and B. `bank_sel` selects the active bank. One table is applied to all three channels.
- Each bank is 1 write port, 3 read ports (R, G, B).
- Host writes always target the shadow bank, which is the bank not selected by `bank_sel`.
- Control FSM, states INIT, IDLE, ARMED.
- INIT: an 8-bit counter walks addresses 0..255 and writes identity (addr→addr) to both banks, one entry per cycle.
  - Lasts 256 cycles, then enters IDLE and sets init_done=1.
  - cfg_ready=0 throughout INIT.
- IDLE: cfg_ready=1; writes are accepted.
  - cfg_commit moves the FSM to ARMED.
  - cfg_wr_en and cfg_commit asserted in the same cycle: the write lands, then the FSM arms.
- ARMED: cfg_ready=0. cfg_wr_en and cfg_commit are ignored.
  - On a vsync rising edge (i_vs=1 with the registered i_vs=0), `bank_sel` toggles, `lut_valid` is set to 1, and the FSM returns to IDLE.
  - That same edge pixel, and every later pixel, uses the new bank.
- Output forced to bypass while `lut_valid`=0 or bypass=1.
- Output RGB forced to 0 when the delayed de is 0.
- Reset, at any point including mid-ARMED:
  - FSM goes to INIT (see Configuration), `bank_sel`=0.
  - All o_* and cfg_ready are 0; init_done=0.
  - Any pending commit is discarded.

## Timing
- Pixel latency is exactly 2 cycles on RGB, vs, hs and de, in every mode.
- Stage 1 registers the inputs and presents the LUT read address.
- Stage 2 registers the LUT read data (or the bypassed pixel) and the output syncs.
- Bank select is sampled in stage 1, so the swap aligns to the vsync-edge pixel.
- A write in cycle N is readable by pixels entering stage 1 from cycle N+1, once that bank becomes active.
- cfg_ready falls in the cycle after cfg_commit. It rises in the cycle after the vsync edge.

## Configuration
- INV_GAMMA_INIT_EN defined:
  - INIT sequence as above; init_done rises 256 cycles after reset release.
  - `lut_valid`=1 at the end of INIT, so identity mapping is active.
- INV_GAMMA_INIT_EN undefined:
  - The INIT state is not built; reset goes straight to IDLE, and init_done=1 one cycle after reset release.
  - Bank contents are undefined and `lut_valid`=0, so output is bypassed until the first commit completes its swap.

## Structure
- Package inv_gamma_pkg holds:
  - the FSM state enum (INIT/IDLE/ARMED);
  - the LUT_DEPTH and PIPE_LAT=2 constants;
  - the 8-bit pixel typedef.
- Sub-module inv_gamma_lut_bank: a 256x8 RAM with 1 write port and 3 registered read ports. It is instantiated twice.

## Test plan
- With INV_GAMMA_INIT_EN, release reset: init_done=1 and cfg_ready=1 after 256 cycles. Pixel R=0x80, de=1 gives o_r=0x80 two cycles later.
- Load the shadow table (addr 128→1, 255→255, 0→0), commit, then drive R=128, G=255, B=0:
  - output stays 128/255/0 until a vsync rise;
  - from that pixel on, output is 1/255/0;
  - cfg_ready is 0 in between.
- While ARMED, cfg_wr_en addr 10 data 0x55 is ignored. After a second commit and swap with no writes, R=10 gives 10.
- Sync pulses emerge exactly 2 cycles later. With de=0 and i_r=0xFF, o_r=0.
- With the loaded table active and bypass=1, R=128 gives 128 with 2-cycle latency.
- Assert rst for 1 cycle while ARMED:
  - all o_* are 0 next cycle and the pending commit is lost;
  - INIT reruns and identity mapping is restored.

Source files
------------

// File: rtl/inv_gamma_pkg.sv
// Shared constants, pixel types and control-FSM states for the inverse-gamma stage.
package inv_gamma_pkg;

  localparam int DATA_W    = 8;
  localparam int LUT_DEPTH = 1 << DATA_W;
  localparam int PIPE_LAT  = 2;

  typedef logic [DATA_W-1:0] pix_t;

  typedef struct packed {
    pix_t r;
    pix_t g;
    pix_t b;
  } rgb_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ARMED = 2'd2
  } state_e;

endpackage

// File: rtl/inv_gamma_lut_bank.sv
// One 256x8 table bank: a single write port and three registered read ports (R, G, B).
module inv_gamma_lut_bank
  import inv_gamma_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_r_i,
  input  logic [7:0] raddr_g_i,
  input  logic [7:0] raddr_b_i,
  output logic [7:0] rdata_r_o,
  output logic [7:0] rdata_g_o,
  output logic [7:0] rdata_b_o
);

  pix_t mem_q [LUT_DEPTH];

  // NOTE: the table array and its read registers have no reset; a reset
  // would turn the array into flops and the read data is masked downstream.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_r_o <= mem_q[raddr_r_i];
    rdata_g_o <= mem_q[raddr_g_i];
    rdata_b_o <= mem_q[raddr_b_i];
  end

endmodule

// File: rtl/inv_gamma_stream.sv
// Streaming degamma stage with a double-buffered table swapped at vsync rise.
// Build option INV_GAMMA_INIT_EN: fill both banks with identity after reset.
module inv_gamma_stream
  import inv_gamma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vs,
  input  logic       i_hs,
  input  logic       i_de,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_vs,
  output logic       o_hs,
  output logic       o_de,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  input  logic       bypass,
  input  logic       cfg_wr_en,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       cfg_commit,
  output logic       cfg_ready,
  output logic       init_done
);

`ifdef INV_GAMMA_INIT_EN
  localparam state_e RST_STATE = INIT;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e state_q, state_d;
  logic   bank_sel_q, bank_sel_d;
  logic   lut_valid_q, lut_valid_d;
  logic   init_done_q, init_done_d;
  logic   vs_rise, wr_accept, init_we;
  pix_t   waddr, wdata;

  logic   s1_vs_q, s1_hs_q, s1_de_q, s1_sel_q, s1_lut_q;
  rgb_t   s1_pix_q;
  logic   s2_vs_q, s2_hs_q, s2_de_q, s2_sel_q, s2_lut_q;
  rgb_t   s2_pix_q;
  rgb_t   rd_a, rd_b, lut_pix, out_pix;

  assign vs_rise   = i_vs & ~s1_vs_q;
  assign cfg_ready = init_done_q && (state_q == IDLE);
  assign wr_accept = cfg_ready & cfg_wr_en;
  assign init_done = init_done_q;

`ifdef INV_GAMMA_INIT_EN
  pix_t init_cnt_q, init_cnt_d;

  assign init_we = (state_q == INIT);
  assign waddr   = init_we ? init_cnt_q : cfg_addr;
  assign wdata   = init_we ? init_cnt_q : cfg_data;

  always_ff @(posedge clk) begin
    if (rst) init_cnt_q <= '0;
    else     init_cnt_q <= init_cnt_d;
  end
`else
  assign init_we = 1'b0;
  assign waddr   = cfg_addr;
  assign wdata   = cfg_data;
`endif

  // NOTE: every always_comb output gets its hold value first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    lut_valid_d = lut_valid_q;
    init_done_d = init_done_q;
`ifdef INV_GAMMA_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif
    unique case (state_q)
      INIT: begin
`ifdef INV_GAMMA_INIT_EN
        init_cnt_d = init_cnt_q + 8'd1;
        if (init_cnt_q == 8'(LUT_DEPTH - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          lut_valid_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        init_done_d = 1'b1;
        if (cfg_ready && cfg_commit) state_d = ARMED;
      end
      ARMED: begin
        if (vs_rise) begin
          state_d     = IDLE;
          bank_sel_d  = ~bank_sel_q;
          lut_valid_d = 1'b1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      bank_sel_q  <= 1'b0;
      lut_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      lut_valid_q <= lut_valid_d;
      init_done_q <= init_done_d;
    end
  end

  // Stage 1 takes the next bank select so the vsync-edge pixel already sees the new table.
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_vs_q, s1_hs_q, s1_de_q, s1_sel_q, s1_lut_q} <= '0;
      {s2_vs_q, s2_hs_q, s2_de_q, s2_sel_q, s2_lut_q} <= '0;
    end else begin
      s1_vs_q  <= i_vs;
      s1_hs_q  <= i_hs;
      s1_de_q  <= i_de;
      s1_sel_q <= bank_sel_d;
      s1_lut_q <= lut_valid_d & ~bypass;
      s2_vs_q  <= s1_vs_q;
      s2_hs_q  <= s1_hs_q;
      s2_de_q  <= s1_de_q;
      s2_sel_q <= s1_sel_q;
      s2_lut_q <= s1_lut_q;
    end
  end

  always_ff @(posedge clk) begin
    s1_pix_q <= '{r: i_r, g: i_g, b: i_b};
    s2_pix_q <= s1_pix_q;
  end

  // The shadow bank is whichever one bank_sel does not select; INIT fills both.
  inv_gamma_lut_bank u_bank_a (
    .clk       (clk),
    .we_i      (init_we | (wr_accept & bank_sel_q)),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_r_i (s1_pix_q.r),
    .raddr_g_i (s1_pix_q.g),
    .raddr_b_i (s1_pix_q.b),
    .rdata_r_o (rd_a.r),
    .rdata_g_o (rd_a.g),
    .rdata_b_o (rd_a.b)
  );

  inv_gamma_lut_bank u_bank_b (
    .clk       (clk),
    .we_i      (init_we | (wr_accept & ~bank_sel_q)),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_r_i (s1_pix_q.r),
    .raddr_g_i (s1_pix_q.g),
    .raddr_b_i (s1_pix_q.b),
    .rdata_r_o (rd_b.r),
    .rdata_g_o (rd_b.g),
    .rdata_b_o (rd_b.b)
  );

  assign lut_pix = s2_sel_q ? rd_b : rd_a;
  assign out_pix = !s2_de_q ? '0 : (s2_lut_q ? lut_pix : s2_pix_q);

  assign o_vs = s2_vs_q;
  assign o_hs = s2_hs_q;
  assign o_de = s2_de_q;
  assign o_r  = out_pix.r;
  assign o_g  = out_pix.g;
  assign o_b  = out_pix.b;

endmodule
